display_hdmi_fifo_fill_ctrl: RTL and testbench

Write-side scheduler for the HDMI pixel dual-clock FIFO. It splits each frame into burst read requests to the frame-buffer memory read master and issues a request only when the FIFO has room for that burst plus every beat already requested but not yet returned. It runs in the FIFO write-clock domain, takes the FIFO write count as input, and tracks outstanding beats until the frame fully drains in.

---
 rtl/display_hdmi_fifo_fill_ctrl.sv | 148 ++++++++++++++
 tb/tb_display_hdmi_fifo_fill_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_hdmi_fifo_fill_ctrl.sv
// HDMI pixel FIFO fill controller: splits a frame into burst read
// requests, each issued only when the FIFO can absorb every beat in flight.
module display_hdmi_fifo_fill_ctrl #(
   parameter int ADDR_WIDTH        = 8,
   parameter int MEM_ADDR_WIDTH    = 32,
   parameter int BURST_LEN         = 16,
   parameter int BYTES_PER_BEAT    = 8,
   parameter int FRAME_BEATS_WIDTH = 24
) (
   input  logic                         i_clk,
   input  logic                         i_arst,
   input  logic                         i_frame_start,
   input  logic [MEM_ADDR_WIDTH-1:0]    i_base_addr,
   input  logic [FRAME_BEATS_WIDTH-1:0] i_frame_beats,
   input  logic [ADDR_WIDTH-1:0]        i_wcnt,
   input  logic                         i_data_valid,
   output logic                         o_req_valid,
   input  logic                         i_req_ready,
   output logic [MEM_ADDR_WIDTH-1:0]    o_req_addr,
   output logic [7:0]                   o_req_len,
   output logic                         o_busy,
   output logic                         o_frame_done,
   output logic                         o_err
);

   localparam int SW = ADDR_WIDTH + 2;
   localparam int OW = ADDR_WIDTH + 1;
   localparam logic [SW-1:0] FIFO_MAX = SW'((2 ** ADDR_WIDTH) - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      REQ,
      DRAIN,
      DONE
   } state_t;

   state_t                         state, state_n;
   logic [MEM_ADDR_WIDTH-1:0]      addr, addr_n, req_addr_n;
   logic [FRAME_BEATS_WIDTH-1:0]   rem, rem_n;
   logic [OW-1:0]                  outst, outst_n;
   logic [8:0]                     len, hs_len;
   logic [SW-1:0]                  need;
   logic [7:0]                     req_len_n;
   logic                           req_valid_n, busy_n, done_n, err_n;
   logic                           hs, bad;

   // Next burst size and the FIFO room it would need, counting beats in flight.
   always_comb begin
      len = 9'(BURST_LEN);
      if (rem < FRAME_BEATS_WIDTH'(BURST_LEN))
         len = 9'(rem);
      need   = SW'(i_wcnt) + SW'(outst) + SW'(len);
      hs     = o_req_valid & i_req_ready;
      hs_len = {1'b0, o_req_len} + 9'd1;
   end

   // Outstanding-beat tracking; a beat with nothing in flight is an error.
   always_comb begin
      outst_n = outst;
      bad     = 1'b0;
      if (hs)
         outst_n = outst + OW'(hs_len) - OW'(i_data_valid);
      else if (i_data_valid) begin
         if (outst == '0)
            bad = 1'b1;
         else
            outst_n = outst - OW'(1);
      end
   end

   // Frame sequencing and registered-output next values.
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      rem_n       = rem;
      req_valid_n = o_req_valid;
      req_addr_n  = o_req_addr;
      req_len_n   = o_req_len;
      done_n      = 1'b0;
      err_n       = o_err | bad;
      unique case (state)
         IDLE: begin
            if (i_frame_start) begin
               addr_n  = i_base_addr;
               rem_n   = i_frame_beats;
               err_n   = 1'b0;
               state_n = (i_frame_beats == '0) ? DONE : CHECK;
            end
         end
         CHECK: begin
            if (need <= FIFO_MAX) begin
               req_valid_n = 1'b1;
               req_addr_n  = addr;
               req_len_n   = 8'(len - 9'd1);
               state_n     = REQ;
            end
         end
         REQ: begin
            if (hs) begin
               req_valid_n = 1'b0;
               rem_n       = rem - FRAME_BEATS_WIDTH'(hs_len);
               addr_n      = addr + MEM_ADDR_WIDTH'(hs_len)
                                  * MEM_ADDR_WIDTH'(BYTES_PER_BEAT);
               state_n     = (rem_n == '0) ? DRAIN : CHECK;
            end
         end
         DRAIN: begin
            if (outst == '0)
               state_n = DONE;
         end
         DONE: begin
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state        <= IDLE;
         addr         <= '0;
         rem          <= '0;
         outst        <= '0;
         o_req_valid  <= 1'b0;
         o_req_addr   <= '0;
         o_req_len    <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         state        <= state_n;
         addr         <= addr_n;
         rem          <= rem_n;
         outst        <= outst_n;
         o_req_valid  <= req_valid_n;
         o_req_addr   <= req_addr_n;
         o_req_len    <= req_len_n;
         o_busy       <= busy_n;
         o_frame_done <= done_n;
         o_err        <= err_n;
      end
   end

endmodule

// File: tb/tb_display_hdmi_fifo_fill_ctrl.sv
// Bench for the HDMI FIFO fill controller: table of frames checked by a
// request scoreboard, plus directed throttle/backpressure/error sequences.
module tb_display_hdmi_fifo_fill_ctrl;

   logic        clk = 1'b0;
   logic        i_arst = 1'b1;
   logic        i_frame_start = 1'b0;
   logic [31:0] i_base_addr = '0;
   logic [23:0] i_frame_beats = '0;
   logic [7:0]  i_wcnt = '0;
   logic        i_data_valid = 1'b0;
   logic        i_req_ready = 1'b0;
   logic        o_req_valid;
   logic [31:0] o_req_addr;
   logic [7:0]  o_req_len;
   logic        o_busy, o_frame_done, o_err;

   always #5 clk = ~clk;

   display_hdmi_fifo_fill_ctrl dut (
      .i_clk(clk), .i_arst(i_arst),
      .i_frame_start(i_frame_start), .i_base_addr(i_base_addr),
      .i_frame_beats(i_frame_beats), .i_wcnt(i_wcnt),
      .i_data_valid(i_data_valid), .o_req_valid(o_req_valid),
      .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
      .o_req_len(o_req_len), .o_busy(o_busy),
      .o_frame_done(o_frame_done), .o_err(o_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   typedef struct {
      logic [31:0] base;
      int          beats;
      int          exp_reqs;
   } vec_t;

   req_t exp_q[$];
   vec_t tbl[5];
   int   vecs = 0;
   int   miscompares = 0;
   int   hs_cnt = 0, done_cnt = 0;
   int   req_beats = 0, ret_beats = 0;
   int   hs0, done0, ret0;
   bit   auto_ret = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference burst split of a frame into the expected request queue.
   task automatic push_model(input logic [31:0] base, input int beats);
      logic [31:0] a;
      int          r, l;
      a = base;
      r = beats;
      while (r > 0) begin
         l = (r < 16) ? r : 16;
         exp_q.push_back('{addr: a, len: 8'(l - 1)});
         a = a + 32'(l * 8);
         r = r - l;
      end
   endtask

   // One clock: observe at the falling edge, drive just after the rising edge.
   task automatic tick();
      req_t e;
      @(negedge clk);
      if (!i_arst && o_req_valid && i_req_ready) begin
         hs_cnt++;
         req_beats += int'(o_req_len) + 1;
         if (exp_q.size() == 0)
            chk("spurious_req", o_req_addr, 64'hdead);
         else begin
            e = exp_q.pop_front();
            chk("req_addr", o_req_addr, e.addr);
            chk("req_len", o_req_len, e.len);
         end
      end
      if (o_frame_done) done_cnt++;
      @(posedge clk);
      #1;
      i_data_valid = 1'b0;
      if (auto_ret && req_beats > ret_beats) begin
         i_data_valid = 1'b1;
         ret_beats++;
      end
   endtask

   task automatic start(input logic [31:0] base, input int beats);
      hs0   = hs_cnt;
      done0 = done_cnt;
      ret0  = ret_beats;
      push_model(base, beats);
      i_base_addr   = base;
      i_frame_beats = 24'(beats);
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
   endtask

   task automatic wait_done(input int beats);
      for (int i = 0; i < 4000; i++) begin
         if (done_cnt != done0) break;
         tick();
      end
      chk("done_seen", 64'(done_cnt != done0), 1);
      tick();
      tick();
      chk("done_once", done_cnt - done0, 1);
      chk("busy_after", o_busy, 0);
      chk("queue_empty", exp_q.size(), 0);
      chk("beats_returned", ret_beats - ret0, beats);
   endtask

   task automatic run_frame(input logic [31:0] base, input int beats,
                            input int exp_reqs);
      i_req_ready = 1'b1;
      i_wcnt      = '0;
      auto_ret    = 1;
      start(base, beats);
      wait_done(beats);
      chk("frame_reqs", hs_cnt - hs0, exp_reqs);
   endtask

   initial begin
      tbl[0] = '{base: 32'h1000, beats: 40, exp_reqs: 3};
      tbl[1] = '{base: 32'h2000, beats: 16, exp_reqs: 1};
      tbl[2] = '{base: 32'h3000, beats: 17, exp_reqs: 2};
      tbl[3] = '{base: 32'h4000, beats: 1,  exp_reqs: 1};
      tbl[4] = '{base: 32'hFFFFFFF0, beats: 20, exp_reqs: 2};

      #1;
      chk("rst_valid", o_req_valid, 0);
      chk("rst_addr", o_req_addr, 0);
      chk("rst_len", o_req_len, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_frame_done, 0);
      chk("rst_err", o_err, 0);
      tick();
      tick();
      i_arst = 1'b0;
      tick();

      for (int v = 0; v < 5; v++)
         run_frame(tbl[v].base, tbl[v].beats, tbl[v].exp_reqs);

      // Empty frame: done two cycles after start, no requests.
      start(32'h1000, 0);
      chk("zero_busy", o_busy, 1);
      chk("zero_done_early", o_frame_done, 0);
      tick();
      chk("zero_done", o_frame_done, 1);
      chk("zero_busy_end", o_busy, 0);
      tick();
      chk("zero_done_pulse", o_frame_done, 0);
      chk("zero_done_cnt", done_cnt - done0, 1);
      chk("zero_reqs", hs_cnt - hs0, 0);

      // FIFO space throttle.
      auto_ret = 0;
      i_wcnt   = 8'd240;
      start(32'h1000, 40);
      for (int i = 0; i < 4; i++) tick();
      chk("throttle_hold", o_req_valid, 0);
      i_wcnt = 8'd239;
      tick();
      chk("throttle_release", o_req_valid, 1);
      i_wcnt   = '0;
      auto_ret = 1;
      wait_done(40);
      chk("throttle_reqs", hs_cnt - hs0, 3);

      // Beats in flight limit further requests.
      auto_ret = 0;
      start(32'h1000, 256);
      for (int i = 0; i < 200; i++) begin
         if (hs_cnt - hs0 >= 15) break;
         tick();
      end
      for (int i = 0; i < 6; i++) tick();
      chk("outst_block", hs_cnt - hs0, 15);
      chk("outst_valid", o_req_valid, 0);
      i_data_valid = 1'b1;
      ret_beats++;
      i_wcnt = 8'd1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      chk("outst_1beat", hs_cnt - hs0, 15);
      i_data_valid = 1'b1;
      ret_beats++;
      tick();
      for (int i = 0; i < 4; i++) tick();
      chk("outst_2beat", hs_cnt - hs0, 16);
      i_wcnt   = '0;
      auto_ret = 1;
      wait_done(256);
      chk("outst_reqs", hs_cnt - hs0, 16);

      // Backpressure holds the request stable.
      i_req_ready = 1'b0;
      start(32'h1000, 40);
      for (int i = 0; i < 20; i++) begin
         if (o_req_valid) break;
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", o_req_valid, 1);
         chk("bp_addr", o_req_addr, 32'h1000);
         chk("bp_len", o_req_len, 15);
         tick();
      end
      i_req_ready = 1'b1;
      tick();
      i_req_ready = 1'b0;
      tick();
      chk("bp_one_hs", hs_cnt - hs0, 1);
      i_req_ready = 1'b1;
      wait_done(40);
      chk("bp_reqs", hs_cnt - hs0, 3);

      // Start pulse during a frame is ignored.
      start(32'h1000, 40);
      tick();
      tick();
      i_base_addr   = 32'h8000;
      i_frame_beats = 24'd5;
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
      wait_done(40);
      chk("mid_start_reqs", hs_cnt - hs0, 3);

      // Sticky error on an unexpected beat, cleared by the next start.
      i_data_valid = 1'b1;
      tick();
      chk("err_set", o_err, 1);
      tick();
      tick();
      chk("err_hold", o_err, 1);
      start(32'h1000, 0);
      chk("err_clear", o_err, 0);
      wait_done(0);

      // Asynchronous reset while a request is pending.
      auto_ret    = 0;
      i_req_ready = 1'b0;
      start(32'h1000, 40);
      for (int i = 0; i < 20; i++) begin
         if (o_req_valid) break;
         tick();
      end
      chk("pre_rst_valid", o_req_valid, 1);
      i_arst = 1'b1;
      #1;
      chk("arst_valid", o_req_valid, 0);
      chk("arst_addr", o_req_addr, 0);
      chk("arst_len", o_req_len, 0);
      chk("arst_busy", o_busy, 0);
      exp_q.delete();
      ret_beats = req_beats;
      tick();
      tick();
      i_arst = 1'b0;
      tick();
      run_frame(32'h1000, 40, 3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, miscompares);
      $finish;
   end

endmodule
